// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_sub_ctrl: bit-serial a - b - bin using one full-subtract cell,  |
// | LSB first, with start/busy/done handshake. Rev 1.0                     |
// +----------------------------------------------------------------------+
module serial_sub_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam logic [1:0]       c_ST_IDLE  = 2'd0;
   localparam logic [1:0]       c_ST_SHIFT = 2'd1;
   localparam logic [1:0]       c_ST_DONE  = 2'd2;
   localparam logic [CNT_W-1:0] c_LAST     = CNT_W'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_next;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] w_sa_next;
   logic             r_br;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             w_d;
   logic             w_bnext;
   logic             w_last;

   assign w_d     = r_sa[0] ^ r_sb[0] ^ r_br;
   assign w_bnext = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
   assign w_last  = (r_cnt == c_LAST);

   // Difference bits refill the minuend register from the top, so after
   // WIDTH shifts it holds the complete result.
   generate
      if (WIDTH == 1) begin : g_w1
         assign w_sa_next = w_d;
      end else begin : g_wn
         assign w_sa_next = {w_d, r_sa[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_ST_IDLE:  if (start) w_state_next = c_ST_SHIFT;
         c_ST_SHIFT: if (w_last) w_state_next = c_ST_DONE;
         c_ST_DONE:  w_state_next = c_ST_IDLE;
         default:    w_state_next = c_ST_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         c_ST_SHIFT: busy = 1'b1;
         c_ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sa   <= '0;
         r_sb   <= '0;
         r_br   <= 1'b0;
         r_cnt  <= '0;
         r_diff <= '0;
         r_bout <= 1'b0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (start) begin
                  r_sa  <= a;
                  r_sb  <= b;
                  r_br  <= bin;
                  r_cnt <= '0;
               end
            end
            c_ST_SHIFT: begin
               r_sa  <= w_sa_next;
               r_sb  <= r_sb >> 1;
               r_br  <= w_bnext;
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_diff <= w_sa_next;
                  r_bout <= w_bnext;
               end
            end
            default: ;
         endcase
      end
   end

   assign diff = r_diff;
   assign bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_sub_ctrl: directed and randomized checks of serial_sub_ctrl |
// | against an arithmetic reference model. Rev 1.0                        |
// +----------------------------------------------------------------------+
module tb_serial_sub_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   int checks   = 0;
   int failures = 0;

   serial_sub_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drives one start from an IDLE negedge, scrambles inputs after acceptance,
   // waits (bounded) for done, then steps one more cycle back to IDLE.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                        output int lat, output int busy_cnt,
                        output logic [7:0] got_d, output logic got_b,
                        output logic done_after, output logic busy_after);
      a = ta; b = tb_; bin = tbin; start = 1'b1;
      lat = 0; busy_cnt = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            start = 1'b0;
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
         end
         if (busy === 1'b1) busy_cnt++;
      end while (done !== 1'b1 && lat < 40);
      got_d = diff;
      got_b = bout;
      @(negedge clk);
      done_after = done;
      busy_after = busy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1;
      a = 8'($urandom); b = 8'($urandom); bin = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (diff !== 8'h00) begin failures++; $display("FAIL reset_diff: got %h expected 00", diff); end
      checks++; if (bout !== 1'b0) begin failures++; $display("FAIL reset_bout: got %b expected 0", bout); end
      start = 1'b0; rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat, bc; logic [7:0] d; logic bo, da, ba;
      do_op(8'h0F, 8'h05, 1'b0, lat, bc, d, bo, da, ba);
      checks++; if (lat !== 9) begin failures++; $display("FAIL basic_latency: got %0d expected 9", lat); end
      checks++; if (d !== 8'h0A) begin failures++; $display("FAIL basic_diff: got %h expected 0a", d); end
      checks++; if (bo !== 1'b0) begin failures++; $display("FAIL basic_bout: got %b expected 0", bo); end
      checks++; if (da !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got %b expected 0", da); end
      checks++; if (ba !== 1'b0) begin failures++; $display("FAIL basic_idle_busy: got %b expected 0", ba); end
   endtask

   task automatic test_underflow();
      int lat, bc; logic [7:0] d; logic bo, da, ba;
      do_op(8'h00, 8'h01, 1'b0, lat, bc, d, bo, da, ba);
      checks++; if (d !== 8'hFF) begin failures++; $display("FAIL underflow1_diff: got %h expected ff", d); end
      checks++; if (bo !== 1'b1) begin failures++; $display("FAIL underflow1_bout: got %b expected 1", bo); end
      do_op(8'h00, 8'hFF, 1'b1, lat, bc, d, bo, da, ba);
      checks++; if (d !== 8'h00) begin failures++; $display("FAIL underflow2_diff: got %h expected 00", d); end
      checks++; if (bo !== 1'b1) begin failures++; $display("FAIL underflow2_bout: got %b expected 1", bo); end
   endtask

   task automatic test_borrow_chain();
      int lat, bc; logic [7:0] d; logic bo, da, ba;
      do_op(8'h80, 8'h7F, 1'b1, lat, bc, d, bo, da, ba);
      checks++; if (d !== 8'h00) begin failures++; $display("FAIL chain_diff: got %h expected 00", d); end
      checks++; if (bo !== 1'b0) begin failures++; $display("FAIL chain_bout: got %b expected 0", bo); end
      checks++; if (bc !== WIDTH + 1) begin failures++; $display("FAIL chain_busy_cycles: got %0d expected %0d", bc, WIDTH + 1); end
      checks++; if (ba !== 1'b0) begin failures++; $display("FAIL chain_busy_drop: got %b expected 0", ba); end
   endtask

   task automatic test_busy_ignore();
      int ndone = 0, done_cyc = -1; logic [7:0] d = 8'h00; logic busy10 = 1'bx;
      int lat, bc; logic [7:0] d2; logic bo, da, ba;
      a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
      for (int cyc = 1; cyc <= 25; cyc++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ndone++;
            if (done_cyc < 0) begin done_cyc = cyc; d = diff; end
         end
         if (cyc == 10) busy10 = busy;
         if (cyc == 3) begin a = 8'hFF; b = 8'h00; end
         start = (cyc == 3) || (cyc == 9);
      end
      start = 1'b0;
      checks++; if (ndone !== 1) begin failures++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
      checks++; if (done_cyc !== 9) begin failures++; $display("FAIL ignore_done_cycle: got %0d expected 9", done_cyc); end
      checks++; if (d !== 8'h0F) begin failures++; $display("FAIL ignore_diff: got %h expected 0f", d); end
      checks++; if (busy10 !== 1'b0) begin failures++; $display("FAIL ignore_start_in_done: busy got %b expected 0", busy10); end
      do_op(8'hFF, 8'h00, 1'b0, lat, bc, d2, bo, da, ba);
      checks++; if (d2 !== 8'hFF) begin failures++; $display("FAIL ignore_next_diff: got %h expected ff", d2); end
   endtask

   task automatic test_reset_mid_op();
      int ndone = 0; int lat, bc; logic [7:0] d; logic bo, da, ba;
      a = 8'h55; b = 8'h11; bin = 1'b0; start = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
         if (cyc == 1) start = 1'b0;
         if (cyc == 4) rst_n = 1'b0;
         if (cyc == 5) begin
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy); end
            checks++; if (diff !== 8'h00) begin failures++; $display("FAIL midrst_diff: got %h expected 00", diff); end
            checks++; if (bout !== 1'b0) begin failures++; $display("FAIL midrst_bout: got %b expected 0", bout); end
            rst_n = 1'b1;
         end
      end
      checks++; if (ndone !== 0) begin failures++; $display("FAIL midrst_no_done: got %0d expected 0", ndone); end
      do_op(8'h55, 8'h11, 1'b0, lat, bc, d, bo, da, ba);
      checks++; if (d !== 8'h44) begin failures++; $display("FAIL midrst_after_diff: got %h expected 44", d); end
      checks++; if (bo !== 1'b0) begin failures++; $display("FAIL midrst_after_bout: got %b expected 0", bo); end
   endtask

   // start held high: operation k is accepted from the inputs of slot 10k
   // and its done is seen on the ninth negedge after that slot.
   task automatic test_back_to_back();
      logic [8:0] expq[$];
      logic [8:0] e;
      int dv;
      int ops = 0;
      for (int n = 0; n < 10000; n++) begin
         a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom); start = 1'b1;
         if (n % 10 == 0) begin
            dv = int'(a) - int'(b) - int'(bin);
            expq.push_back({(dv < 0), 8'(dv)});
         end
         @(negedge clk);
         checks++;
         if (done !== ((n + 1) % 10 == 9)) begin
            failures++;
            $display("FAIL b2b_done_timing slot %0d: got %b expected %b", n + 1, done, ((n + 1) % 10 == 9));
         end
         if (done === 1'b1 && expq.size() > 0) begin
            e = expq.pop_front();
            ops++;
            checks++;
            if ({bout, diff} !== e) begin
               failures++;
               $display("FAIL b2b_result op %0d: got bout=%b diff=%h expected bout=%b diff=%h", ops, bout, diff, e[8], e[7:0]);
            end
         end
      end
      start = 1'b0;
      checks++; if (ops !== 1000) begin failures++; $display("FAIL b2b_op_count: got %0d expected 1000", ops); end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      test_reset();
      test_basic();
      test_underflow();
      test_borrow_chain();
      test_busy_ignore();
      test_reset_mid_op();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
